ahb_arbiter_mp: RTL and testbench



---
 rtl/ahb_arbiter_mp_if.sv | 26 ++
 rtl/ahb_arbiter_mp.sv | 124 ++++++++++++
 tb/tb_ahb_arbiter_mp.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_mp_if.sv
// Bus-side signals shared between the AHB masters and one arbiter instance.
// The master modport is the requesting side; the slave modport is the arbiter.
interface ahb_arbiter_mp_if #(
    parameter int MAS_NUM = 4,
    parameter int MW      = $clog2(MAS_NUM)
);
    logic [MAS_NUM-1:0] hbusreq;
    logic [MAS_NUM-1:0] hlock;
    logic [1:0]         htrans;
    logic [2:0]         hburst;
    logic               hready;
    logic [MAS_NUM-1:0] hgrant;
    logic [MW-1:0]      hmaster;
    logic [MW-1:0]      hmaster_d;
    logic               hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter_mp.sv
// AHB arbiter for one slave port: fixed-priority or round-robin selection,
// with bursts, undefined-length INCR and locked sequences holding ownership.
module ahb_arbiter_mp #(
    parameter int MAS_NUM  = 4,
    parameter int ARB_MODE = 1,
    parameter int DEF_MAS  = 0,
    parameter int MW       = $clog2(MAS_NUM)
) (
    input logic             hclk,
    input logic             hreset,
    ahb_arbiter_mp_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_HOLD_INCR, ST_LOCKED} state_t;

    localparam logic [1:0]    TR_IDLE   = 2'd0;
    localparam logic [1:0]    TR_NONSEQ = 2'd2;
    localparam logic [1:0]    TR_SEQ    = 2'd3;
    localparam logic [2:0]    HB_SINGLE = 3'd0;
    localparam logic [2:0]    HB_INCR   = 3'd1;
    localparam logic [MW-1:0] DEF_IDX   = MW'(DEF_MAS);

    state_t             state;
    logic [MW-1:0]      owner;
    logic [MW-1:0]      owner_d;
    logic [MW-1:0]      rr_ptr;
    logic [MAS_NUM-1:0] grant;
    logic               mastlock;
    logic [3:0]         beat_cnt;

    logic [MW-1:0]      winner;
    logic               any_req;
    logic               own_lock;
    logic               arb_now;

    // Beats remaining after the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_last(input logic [2:0] hb);
        case (hb)
            3'd2, 3'd3: burst_last = 4'd3;
            3'd4, 3'd5: burst_last = 4'd7;
            3'd6, 3'd7: burst_last = 4'd15;
            default:    burst_last = 4'd0;
        endcase
    endfunction

    always_comb begin : arbitrate
        int idx;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        winner  = DEF_IDX;
        any_req = |bus.hbusreq;
        idx     = 0;
        if (ARB_MODE == 0) begin
            for (int i = MAS_NUM - 1; i >= 0; i--)
                if (bus.hbusreq[i]) winner = MW'(i);
        end else begin
            // Descending offsets so the nearest requester after rr_ptr wins last.
            for (int off = MAS_NUM; off >= 1; off--) begin
                idx = int'(rr_ptr) + off;
                if (idx >= MAS_NUM) idx = idx - MAS_NUM;
                if (bus.hbusreq[idx]) winner = MW'(idx);
            end
        end
    end

    always_comb begin : decide
        own_lock = bus.hlock[owner];
        arb_now  = 1'b0;
        unique case (state)
            ST_LOCKED:    arb_now = !own_lock &&
                                    (bus.htrans == TR_IDLE || bus.htrans == TR_NONSEQ);
            ST_BURST:     arb_now = (bus.htrans == TR_IDLE || bus.htrans == TR_NONSEQ) ||
                                    (bus.htrans == TR_SEQ && beat_cnt == 4'd1);
            ST_HOLD_INCR: arb_now = !bus.hbusreq[owner];
            default:      arb_now = own_lock ||
                                    !(bus.htrans == TR_NONSEQ && bus.hburst != HB_SINGLE);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and every register
    // is cleared by the asynchronous reset so nothing resumes after it is released.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            owner    <= DEF_IDX;
            owner_d  <= DEF_IDX;
            rr_ptr   <= DEF_IDX;
            grant    <= MAS_NUM'(1) << DEF_MAS;
            mastlock <= 1'b0;
            beat_cnt <= 4'd0;
        end else if (bus.hready) begin
            owner_d <= owner;
            if (arb_now) begin
                beat_cnt <= 4'd0;
                if (own_lock) begin
                    state    <= ST_LOCKED;
                    mastlock <= 1'b1;
                end else begin
                    owner <= winner;
                    grant <= MAS_NUM'(1) << winner;
                    if (any_req && winner != owner) rr_ptr <= winner;
                    state    <= bus.hlock[winner] ? ST_LOCKED : ST_IDLE;
                    mastlock <= bus.hlock[winner];
                end
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.hburst == HB_INCR) begin
                            state <= ST_HOLD_INCR;
                        end else begin
                            state    <= ST_BURST;
                            beat_cnt <= burst_last(bus.hburst);
                        end
                    end
                    ST_BURST: if (bus.htrans == TR_SEQ) beat_cnt <= beat_cnt - 4'd1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.hgrant    = grant;
    assign bus.hmaster   = owner;
    assign bus.hmaster_d = owner_d;
    assign bus.hmastlock = mastlock;
endmodule

// File: tb/tb_ahb_arbiter_mp.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the same
// stimulus; expected owners are queued when a beat is driven and checked after the edge.
module tb_ahb_arbiter_mp;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SGL = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        int         rr_m;   // -1 means not checked
        int         rr_d;
        int         rr_lk;
        int         fx_m;
    } vec_t;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    ahb_arbiter_mp_if #(.MAS_NUM(4)) rr_bus ();
    ahb_arbiter_mp_if #(.MAS_NUM(4)) fx_bus ();

    ahb_arbiter_mp #(.MAS_NUM(4), .ARB_MODE(1), .DEF_MAS(0)) u_rr (
        .hclk(hclk), .hreset(hreset), .bus(rr_bus)
    );
    ahb_arbiter_mp #(.MAS_NUM(4), .ARB_MODE(0), .DEF_MAS(0)) u_fx (
        .hclk(hclk), .hreset(hreset), .bus(fx_bus)
    );

    always #5 hclk = ~hclk;

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock,
                                input logic [1:0] tr, input logic [2:0] hb, input logic rdy,
                                input int rm, input int rd, input int rl, input int fm);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = tr; v.burst = hb; v.ready = rdy;
        v.rr_m = rm; v.rr_d = rd; v.rr_lk = rl; v.fx_m = fm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rr_bus.hbusreq = v.req;   fx_bus.hbusreq = v.req;
        rr_bus.hlock   = v.lock;  fx_bus.hlock   = v.lock;
        rr_bus.htrans  = v.trans; fx_bus.htrans  = v.trans;
        rr_bus.hburst  = v.burst; fx_bus.hburst  = v.burst;
        rr_bus.hready  = v.ready; fx_bus.hready  = v.ready;
    endtask

    task automatic compare_out(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            if (e.rr_m >= 0) begin
                check({tag, " rr hmaster"}, 32'(rr_bus.hmaster), e.rr_m);
                check({tag, " rr hgrant"}, 32'(rr_bus.hgrant), 32'd1 << e.rr_m);
            end
            if (e.rr_d >= 0) check({tag, " rr hmaster_d"}, 32'(rr_bus.hmaster_d), e.rr_d);
            if (e.rr_lk >= 0) check({tag, " rr hmastlock"}, 32'(rr_bus.hmastlock), e.rr_lk);
            if (e.fx_m >= 0) begin
                check({tag, " fx hmaster"}, 32'(fx_bus.hmaster), e.fx_m);
                check({tag, " fx hgrant"}, 32'(fx_bus.hgrant), 32'd1 << e.fx_m);
            end
        end
    endtask

    // Drive one beat, queue its expectation, and check it just after the edge.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        exp_q.push_back(v);
        @(posedge hclk);
        #1;
        compare_out(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rr hgrant"}, 32'(rr_bus.hgrant), 32'h1);
        check({tag, " rr hmaster"}, 32'(rr_bus.hmaster), 32'd0);
        check({tag, " rr hmaster_d"}, 32'(rr_bus.hmaster_d), 32'd0);
        check({tag, " rr hmastlock"}, 32'(rr_bus.hmastlock), 32'd0);
        check({tag, " fx hgrant"}, 32'(fx_bus.hgrant), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs: outputs must sit at reset values.
        for (int i = 0; i < 3; i++) begin
            drive(mk(4'($urandom), 4'($urandom), 2'($urandom), 3'($urandom), 1'b1, -1, -1, -1, -1));
            @(negedge hclk);
            check_reset_values($sformatf("reset[%0d]", i));
        end
        drive(mk(4'b0000, 4'b0000, IDLE, SGL, 1'b1, -1, -1, -1, -1));
        @(posedge hclk);
        #1 hreset = 1'b0;

        // Release, RR rotation with a wait state, then fixed priority with master 1 dropping.
        tbl.push_back(mk(4'b0000, 4'b0000, IDLE, SGL, 1'b1, 0, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 2, 1, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 3, 2, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 0, 3, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 2, 1, 0, 0));
        tbl.push_back(mk(4'b1110, 4'b0000, NSQ, SGL, 1'b1, 3, 2, 0, 1));
        tbl.push_back(mk(4'b1110, 4'b0000, NSQ, SGL, 1'b1, 1, 3, 0, 1));
        tbl.push_back(mk(4'b1100, 4'b0000, NSQ, SGL, 1'b1, 2, 1, 0, 2));
        tbl.push_back(mk(4'b1100, 4'b0000, NSQ, SGL, 1'b1, 3, 2, 0, 2));
        tbl.push_back(mk(4'b1100, 4'b0000, NSQ, SGL, 1'b1, 2, 3, 0, 2));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl[%0d]", i));

        // INCR8 from master 2 with three wait states and one BUSY.
        step(mk(4'b1111, 4'b0000, NSQ, INCR8, 1'b1, 2, 2, 0, 2), "incr8 nonseq");
        step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 2, 2, 0, 2), "incr8 seq1");
        step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 2, 2, 0, 2), "incr8 seq2");
        for (int i = 0; i < 3; i++)
            step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b0, 2, 2, 0, 2), "incr8 wait");
        step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 2, 2, 0, 2), "incr8 seq3");
        step(mk(4'b1111, 4'b0000, BUSY, INCR8, 1'b1, 2, 2, 0, 2), "incr8 busy");
        for (int i = 4; i <= 6; i++)
            step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 2, 2, 0, 2), $sformatf("incr8 seq%0d", i));
        step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 3, 2, 0, 0), "incr8 last");
        step(mk(4'b1111, 4'b0000, IDLE, SGL, 1'b1, 0, 3, 0, 0), "incr8 after");

        // Master 1 locks across two INCR4 bursts, then releases on IDLE.
        step(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 1, 0, 0, 0), "lock grant");
        step(mk(4'b1111, 4'b0010, IDLE, SGL, 1'b1, 1, 1, 1, 0), "lock enter");
        for (int b = 0; b < 2; b++) begin
            step(mk(4'b1111, 4'b0010, NSQ, INCR4, 1'b1, 1, 1, 1, 0), "lock nonseq");
            for (int i = 0; i < 3; i++)
                step(mk(4'b1111, 4'b0010, SEQ, INCR4, 1'b1, 1, 1, 1, 0), "lock seq");
        end
        step(mk(4'b1111, 4'b0000, IDLE, SGL, 1'b1, 2, 1, 0, 0), "lock release");

        // INCR16 cut short by a NONSEQ after five beats.
        step(mk(4'b1111, 4'b0000, NSQ, INCR16, 1'b1, 2, 2, 0, 0), "cut nonseq");
        for (int i = 0; i < 4; i++)
            step(mk(4'b1111, 4'b0000, SEQ, INCR16, 1'b1, 2, 2, 0, 0), "cut seq");
        step(mk(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 3, 2, 0, 0), "cut abort");
        step(mk(4'b1111, 4'b0000, IDLE, SGL, 1'b1, 0, 3, 0, 0), "cut after");

        // Undefined-length INCR holds until the owner drops its request.
        step(mk(4'b1111, 4'b0000, NSQ, INCR, 1'b1, 0, 0, 0, 0), "hold nonseq");
        step(mk(4'b1111, 4'b0000, SEQ, INCR, 1'b1, 0, 0, 0, 0), "hold seq");
        step(mk(4'b1110, 4'b0000, SEQ, INCR, 1'b1, 1, 0, 0, 1), "hold drop");

        // Reset pulsed at beat 3 of an INCR8: outputs clear without a clock edge.
        step(mk(4'b1111, 4'b0000, NSQ, INCR8, 1'b1, 1, 1, 0, 1), "rst nonseq");
        step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 1, 1, 0, 1), "rst seq1");
        step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 1, 1, 0, 1), "rst seq2");
        #2 hreset = 1'b1;
        #1 check_reset_values("rst async");
        @(posedge hclk);
        #1 check_reset_values("rst held");
        hreset = 1'b0;
        step(mk(4'b1111, 4'b0000, SEQ, INCR8, 1'b1, 1, 0, 0, 0), "rst after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
